// File: rtl/vga_timing_gen.sv
// Raster timing generator: h/v counters on a pixel strobe, scaled framebuffer address,
// and sync/data-enable outputs delayed to line up with framebuffer read latency.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int SCALE_X  = 1,
    parameter int SCALE_Y  = 1,
    parameter int STRIDE   = 640,
    parameter int BASE     = 0,
    parameter int ADDR_W   = 19,
    parameter int PIPE     = 2
) (
    input  logic              clock,
    input  logic              rst_i,
    input  logic              pix_ce,
    output logic [15:0]       x,
    output logic [15:0]       y,
    output logic              fetch_en,
    output logic [ADDR_W-1:0] addr,
    output logic              sof,
    output logic              eol,
    output logic              hs,
    output logic              vs,
    output logic              de
);

    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [15:0] H_LAST     = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST     = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT      = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT      = 16'(V_ACTIVE);
    localparam logic [15:0] H_ACT_LAST = 16'(H_ACTIVE - 1);
    localparam logic [15:0] HS_BEG     = 16'(H_ACTIVE + H_FRONT);
    localparam logic [15:0] HS_END     = 16'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [15:0] VS_BEG     = 16'(V_ACTIVE + V_FRONT);
    localparam logic [15:0] VS_END     = 16'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [15:0] XS_LAST    = 16'(SCALE_X - 1);
    localparam logic [15:0] YS_LAST    = 16'(SCALE_Y - 1);

    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    logic [15:0]       h_q, h_d;
    logic [15:0]       v_q, v_d;
    logic [15:0]       xs_q, xs_d;
    logic [15:0]       ys_q, ys_d;
    logic [ADDR_W-1:0] lb_q, lb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              h_last, v_last;
    logic              hs_raw, vs_raw;
    logic [2:0]        raw_sig;
    logic [2:0]        dly_sig;

    assign h_last   = (h_q == H_LAST);
    assign v_last   = (v_q == V_LAST);
    assign fetch_en = (h_q < H_ACT) && (v_q < V_ACT);
    assign hs_raw   = (h_q >= HS_BEG) && (h_q < HS_END);
    assign vs_raw   = (v_q >= VS_BEG) && (v_q < VS_END);

    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        xs_d   = xs_q;
        ys_d   = ys_q;
        lb_d   = lb_q;
        addr_d = addr_q;
        if (pix_ce) begin
            if (h_last) begin
                h_d = '0;
                v_d = v_last ? '0 : v_q + 16'd1;
            end else begin
                h_d = h_q + 16'd1;
            end

            if (h_last && v_last) begin
                lb_d   = BASE_A;
                addr_d = BASE_A;
                xs_d   = '0;
                ys_d   = '0;
            end else if (h_last) begin
                // Line repetition: replay the same base until SCALE_Y lines have used it.
                if (v_q < V_ACT) begin
                    xs_d = '0;
                    if (ys_q == YS_LAST) begin
                        ys_d   = '0;
                        lb_d   = lb_q + STRIDE_A;
                        addr_d = lb_q + STRIDE_A;
                    end else begin
                        ys_d   = ys_q + 16'd1;
                        addr_d = lb_q;
                    end
                end
            end else if (fetch_en && (h_q != H_ACT_LAST)) begin
                // Stop at the last active pixel so addr holds that value through blanking.
                if (xs_q == XS_LAST) begin
                    xs_d   = '0;
                    addr_d = addr_q + ONE_A;
                end else begin
                    xs_d = xs_q + 16'd1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (rst_i) begin
            h_q    <= H_LAST;
            v_q    <= V_LAST;
            xs_q   <= '0;
            ys_q   <= '0;
            lb_q   <= BASE_A;
            addr_q <= BASE_A;
        end else begin
            h_q    <= h_d;
            v_q    <= v_d;
            xs_q   <= xs_d;
            ys_q   <= ys_d;
            lb_q   <= lb_d;
            addr_q <= addr_d;
        end
    end

    assign raw_sig = {hs_raw, vs_raw, fetch_en};

    generate
        if (PIPE == 0) begin : g_no_dly
            assign dly_sig = raw_sig;
        end else begin : g_dly
            logic [2:0] pipe_q [PIPE];
            logic [2:0] pipe_d [PIPE];

            always_comb begin
                pipe_d[0] = raw_sig;
                for (int i = 1; i < PIPE; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            // Shifts every clock regardless of pix_ce; reset flushes any partial pulse.
            always_ff @(posedge clock) begin
                if (rst_i) begin
                    for (int i = 0; i < PIPE; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < PIPE; i++) begin
                        pipe_q[i] <= pipe_d[i];
                    end
                end
            end

            assign dly_sig = pipe_q[PIPE-1];
        end
    endgenerate

    assign x    = h_q;
    assign y    = v_q;
    assign addr = addr_q;
    assign sof  = (h_q == 16'd0) && (v_q == 16'd0);
    assign eol  = h_last;
    assign hs   = dly_sig[2] ? HS_ON : ~HS_ON;
    assign vs   = dly_sig[1] ? VS_ON : ~VS_ON;
    assign de   = dly_sig[0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: five instances with different timing/scale/pipe settings,
// checked against a coordinate-based model through expected-value queues.
module tb_vga_timing_gen;

    typedef struct {
        int ha; int hf; int hsy; int hb;
        int va; int vf; int vsy; int vb;
        int hpol; int vpol;
        int sx; int sy; int stride; int base; int pipe;
    } cfg_t;

    typedef struct {
        int x; int y; bit fe; bit sof; bit eol; int addr;
    } exp_t;

    logic        clock;
    logic        rst_i;
    logic [4:0]  pce;
    logic [15:0] xo [5];
    logic [15:0] yo [5];
    logic [18:0] ao [5];
    logic        fe [5];
    logic        so [5];
    logic        eo [5];
    logic        hso [5];
    logic        vso [5];
    logic        deo [5];

    cfg_t cfg [5];
    int   n_chk  = 0;
    int   n_pass = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // 0: default H, short frame
    vga_timing_gen #(.V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2)) u_def (
        .clock(clock), .rst_i(rst_i), .pix_ce(pce[0]), .x(xo[0]), .y(yo[0]),
        .fetch_en(fe[0]), .addr(ao[0]), .sof(so[0]), .eol(eo[0]),
        .hs(hso[0]), .vs(vso[0]), .de(deo[0]));

    // 1: 2x2 scaled
    vga_timing_gen #(.V_ACTIVE(6), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .SCALE_X(2), .SCALE_Y(2), .STRIDE(320), .BASE(16)) u_scl (
        .clock(clock), .rst_i(rst_i), .pix_ce(pce[1]), .x(xo[1]), .y(yo[1]),
        .fetch_en(fe[1]), .addr(ao[1]), .sof(so[1]), .eol(eo[1]),
        .hs(hso[1]), .vs(vso[1]), .de(deo[1]));

    // 2: small timing, PIPE=3
    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .STRIDE(8), .PIPE(3)) u_p3 (
        .clock(clock), .rst_i(rst_i), .pix_ce(pce[2]), .x(xo[2]), .y(yo[2]),
        .fetch_en(fe[2]), .addr(ao[2]), .sof(so[2]), .eol(eo[2]),
        .hs(hso[2]), .vs(vso[2]), .de(deo[2]));

    // 3: small timing, PIPE=0
    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .STRIDE(8), .PIPE(0)) u_p0 (
        .clock(clock), .rst_i(rst_i), .pix_ce(pce[3]), .x(xo[3]), .y(yo[3]),
        .fetch_en(fe[3]), .addr(ao[3]), .sof(so[3]), .eol(eo[3]),
        .hs(hso[3]), .vs(vso[3]), .de(deo[3]));

    // 4: small timing, positive syncs, nonzero base
    vga_timing_gen #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .HS_POL(1), .VS_POL(1), .STRIDE(8), .BASE(100)) u_sml (
        .clock(clock), .rst_i(rst_i), .pix_ce(pce[4]), .x(xo[4]), .y(yo[4]),
        .fetch_en(fe[4]), .addr(ao[4]), .sof(so[4]), .eol(eo[4]),
        .hs(hso[4]), .vs(vso[4]), .de(deo[4]));

    function automatic int ht(input cfg_t c);
        return c.ha + c.hf + c.hsy + c.hb;
    endfunction

    function automatic int vt(input cfg_t c);
        return c.va + c.vf + c.vsy + c.vb;
    endfunction

    // Position after n pixel strobes since reset (n=0 is the reset position).
    function automatic void pos(input cfg_t c, input int n, output int h, output int v);
        int tot;
        int p;
        tot = ht(c) * vt(c);
        p   = (n + tot - 1) % tot;
        h   = p % ht(c);
        v   = p / ht(c);
    endfunction

    function automatic logic [2:0] raw_of(input cfg_t c, input int h, input int v);
        logic hs_a, vs_a, de_a;
        hs_a = (h >= c.ha + c.hf) && (h < c.ha + c.hf + c.hsy);
        vs_a = (v >= c.va + c.vf) && (v < c.va + c.vf + c.vsy);
        de_a = (h < c.ha) && (v < c.va);
        return {hs_a, vs_a, de_a};
    endfunction

    function automatic logic [2:0] pins_of(input cfg_t c, input logic [2:0] r);
        logic hp, vp;
        hp = (c.hpol != 0);
        vp = (c.vpol != 0);
        return {r[2] ? hp : ~hp, r[1] ? vp : ~vp, r[0]};
    endfunction

    function automatic int exp_addr(input cfg_t c, input int h, input int v);
        return (c.base + (v / c.sy) * c.stride + (h / c.sx)) % (1 << 19);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        pce   = '0;
        tick();
    endtask

    task automatic test_reset();
        logic [41:0] got, want;
        rst_i = 1'b1;
        pce   = '1;
        tick();
        tick();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 5; i++) begin
                got  = {xo[i], yo[i], fe[i], so[i], eo[i], deo[i], hso[i], vso[i], ao[i][3:0]};
                want = {16'(ht(cfg[i]) - 1), 16'(vt(cfg[i]) - 1), 1'b0, 1'b0, 1'b1, 1'b0,
                        (cfg[i].hpol == 0), (cfg[i].vpol == 0), 4'(cfg[i].base)};
                n_chk++;
                if (got !== want)
                    $display("FAIL reset_state inst=%0d pass=%0d got=%h want=%h", i, pass, got, want);
                else
                    n_pass++;
            end
            rst_i = 1'b0;
            pce   = '0;
            tick();
        end
    endtask

    task automatic test_sync_de();
        cfg_t c;
        logic [2:0] dq [$];
        logic [2:0] got, want;
        int h, v, n, tot;
        int hs_run, vs_run, de_run, de_cnt, vs_fall_k, vs_falls;
        logic hs_prev, vs_prev, de_prev;
        c   = cfg[0];
        tot = ht(c) * vt(c);
        apply_reset();
        dq.delete();
        repeat (c.pipe) dq.push_back(3'b000);
        n = 0; hs_run = 0; vs_run = 0; de_run = 0; de_cnt = 0; vs_fall_k = -1; vs_falls = 0;
        hs_prev = hso[0]; vs_prev = vso[0]; de_prev = deo[0];
        rst_i = 1'b0;
        for (int k = 1; k <= 2 * tot + 4; k++) begin
            pce[0] = 1'b1;
            tick();
            n++;
            pos(c, n, h, v);
            dq.push_back(raw_of(c, h, v));
            want = pins_of(c, dq.pop_front());
            got  = {hso[0], vso[0], deo[0]};
            n_chk++;
            if (got !== want) $display("FAIL sync_de k=%0d got=%b want=%b", k, got, want);
            else n_pass++;

            if (hs_prev && !hso[0]) begin
                n_chk++;
                if (xo[0] !== 16'(c.ha + c.hf + c.pipe))
                    $display("FAIL hs_start got x=%0d want %0d", xo[0], c.ha + c.hf + c.pipe);
                else n_pass++;
            end
            if (!hs_prev && hso[0]) begin
                n_chk++;
                if (hs_run !== c.hsy) $display("FAIL hs_width got %0d want %0d", hs_run, c.hsy);
                else n_pass++;
                hs_run = 0;
            end
            if (!hso[0]) hs_run++;

            if (vs_prev && !vso[0]) begin
                vs_falls++;
                n_chk++;
                if (xo[0] !== 16'(c.pipe)) $display("FAIL vs_at_h0 got x=%0d want %0d", xo[0], c.pipe);
                else n_pass++;
                if (vs_fall_k >= 0) begin
                    n_chk++;
                    if (k - vs_fall_k !== tot) $display("FAIL vs_period got %0d want %0d", k - vs_fall_k, tot);
                    else n_pass++;
                end
                vs_fall_k = k;
            end
            if (!vs_prev && vso[0]) begin
                n_chk++;
                if (vs_run !== c.vsy * ht(c)) $display("FAIL vs_width got %0d want %0d", vs_run, c.vsy * ht(c));
                else n_pass++;
                vs_run = 0;
            end
            if (!vso[0]) vs_run++;

            if (de_prev && !deo[0]) begin
                n_chk++;
                if (de_run !== c.ha) $display("FAIL de_width got %0d want %0d", de_run, c.ha);
                else n_pass++;
                de_run = 0;
            end
            if (deo[0]) de_run++;
            if (deo[0] && k <= tot) de_cnt++;
            hs_prev = hso[0]; vs_prev = vso[0]; de_prev = deo[0];
        end
        n_chk++;
        if (de_cnt !== c.ha * c.va) $display("FAIL de_per_frame got %0d want %0d", de_cnt, c.ha * c.va);
        else n_pass++;
        n_chk++;
        if (vs_falls !== 2) $display("FAIL vs_pulses got %0d want 2", vs_falls);
        else n_pass++;
    endtask

    task automatic test_fetch();
        cfg_t c;
        exp_t fq [$];
        exp_t ex;
        logic [34:0] got, want;
        int h, v, n, tot;
        logic ce;
        c   = cfg[0];
        tot = ht(c) * vt(c);
        apply_reset();
        fq.delete();
        n = 0;
        rst_i = 1'b0;
        for (int k = 0; k < 20000 && n < tot + 2; k++) begin
            ce = (k == 0) || ($urandom_range(0, 3) != 0);
            pce[0] = ce;
            if (ce) n++;
            pos(c, n, h, v);
            ex.x = h; ex.y = v;
            ex.fe = (h < c.ha) && (v < c.va);
            ex.sof = (h == 0) && (v == 0);
            ex.eol = (h == ht(c) - 1);
            ex.addr = exp_addr(c, h, v);
            fq.push_back(ex);
            tick();
            ex   = fq.pop_front();
            got  = {xo[0], yo[0], fe[0], so[0], eo[0]};
            want = {16'(ex.x), 16'(ex.y), ex.fe, ex.sof, ex.eol};
            n_chk++;
            if (got !== want) $display("FAIL fetch_side k=%0d got=%h want=%h", k, got, want);
            else n_pass++;
            if (ex.fe) begin
                n_chk++;
                if (ao[0] !== 19'(ex.addr)) $display("FAIL addr x=%0d y=%0d got %0d want %0d", ex.x, ex.y, ao[0], ex.addr);
                else n_pass++;
            end
            if (ce && h == 639 && v == 0) begin
                n_chk++;
                if (ao[0] !== 19'd639) $display("FAIL addr_639_0 got %0d want 639", ao[0]);
                else n_pass++;
            end
            if (ce && h == 0 && v == 1) begin
                n_chk++;
                if (ao[0] !== 19'd640) $display("FAIL addr_0_1 got %0d want 640", ao[0]);
                else n_pass++;
            end
            if (ce && h == 639 && v == 3) begin
                n_chk++;
                if (ao[0] !== 19'd2559) $display("FAIL addr_last got %0d want 2559", ao[0]);
                else n_pass++;
            end
            if (ce && n == tot + 1) begin
                n_chk++;
                if ({so[0], ao[0]} !== {1'b1, 19'd0}) $display("FAIL sof_reload got sof=%b addr=%0d want 1/0", so[0], ao[0]);
                else n_pass++;
            end
        end
        n_chk++;
        if (n < tot + 2) $display("FAIL fetch_budget got %0d strobes want %0d", n, tot + 2);
        else n_pass++;
    endtask

    task automatic test_scaled();
        cfg_t c;
        exp_t fq [$];
        exp_t ex;
        int h, v, tot;
        c   = cfg[1];
        tot = ht(c) * vt(c);
        apply_reset();
        fq.delete();
        rst_i = 1'b0;
        for (int n = 1; n <= tot + 1; n++) begin
            pce[1] = 1'b1;
            pos(c, n, h, v);
            ex.x = h; ex.y = v;
            ex.fe = (h < c.ha) && (v < c.va);
            ex.sof = (h == 0) && (v == 0);
            ex.eol = (h == ht(c) - 1);
            ex.addr = exp_addr(c, h, v);
            fq.push_back(ex);
            tick();
            ex = fq.pop_front();
            n_chk++;
            if ({xo[1], yo[1], fe[1]} !== {16'(ex.x), 16'(ex.y), ex.fe})
                $display("FAIL scaled_xy n=%0d got x=%0d y=%0d fe=%b", n, xo[1], yo[1], fe[1]);
            else n_pass++;
            if (ex.fe) begin
                n_chk++;
                if (ao[1] !== 19'(ex.addr)) $display("FAIL scaled_addr x=%0d y=%0d got %0d want %0d", ex.x, ex.y, ao[1], ex.addr);
                else n_pass++;
            end
            if (h == 1 && v == 0) begin
                n_chk++;
                if (ao[1] !== 19'd16) $display("FAIL scaled_repeat_px got %0d want 16", ao[1]);
                else n_pass++;
            end
            if (h == 639 && v == 1) begin
                n_chk++;
                if (ao[1] !== 19'd335) $display("FAIL scaled_repeat_line got %0d want 335", ao[1]);
                else n_pass++;
            end
            if (h == 0 && v == 2) begin
                n_chk++;
                if (ao[1] !== 19'd336) $display("FAIL scaled_line2 got %0d want 336", ao[1]);
                else n_pass++;
            end
            if (h == 639 && v == 5) begin
                n_chk++;
                if (ao[1] !== 19'd975) $display("FAIL scaled_last got %0d want 975", ao[1]);
                else n_pass++;
            end
            if (n == tot + 1) begin
                n_chk++;
                if ({so[1], ao[1]} !== {1'b1, 19'd16}) $display("FAIL scaled_reload got sof=%b addr=%0d", so[1], ao[1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_pipe();
        logic [2:0] dq3 [$];
        logic [2:0] dq0 [$];
        logic [2:0] want3, want0;
        int h, v, fe_rise_k;
        logic fe_prev, de_prev, hs_prev;
        apply_reset();
        dq3.delete(); dq0.delete();
        repeat (cfg[2].pipe) dq3.push_back(3'b000);
        fe_rise_k = -1;
        fe_prev = fe[2]; de_prev = deo[2]; hs_prev = hso[2];
        rst_i = 1'b0;
        for (int n = 1; n <= 2 * ht(cfg[2]) * vt(cfg[2]) + 4; n++) begin
            pce[2] = 1'b1;
            pce[3] = 1'b1;
            tick();
            pos(cfg[2], n, h, v);
            dq3.push_back(raw_of(cfg[2], h, v));
            dq0.push_back(raw_of(cfg[3], h, v));
            want3 = pins_of(cfg[2], dq3.pop_front());
            want0 = pins_of(cfg[3], dq0.pop_front());
            n_chk++;
            if ({hso[2], vso[2], deo[2]} !== want3)
                $display("FAIL pipe3_out n=%0d got=%b want=%b", n, {hso[2], vso[2], deo[2]}, want3);
            else n_pass++;
            n_chk++;
            if ({hso[3], vso[3], deo[3]} !== want0)
                $display("FAIL pipe0_out n=%0d got=%b want=%b", n, {hso[3], vso[3], deo[3]}, want0);
            else n_pass++;
            n_chk++;
            if (deo[3] !== fe[3]) $display("FAIL pipe0_de n=%0d got de=%b want fetch_en=%b", n, deo[3], fe[3]);
            else n_pass++;

            if (!fe_prev && fe[2]) fe_rise_k = n;
            if (!de_prev && deo[2]) begin
                n_chk++;
                if (n - fe_rise_k !== 3) $display("FAIL pipe3_de_lag got %0d want 3", n - fe_rise_k);
                else n_pass++;
            end
            if (hs_prev && !hso[2]) begin
                n_chk++;
                if (xo[2] !== 16'd13) $display("FAIL pipe3_hs_fall got x=%0d want 13", xo[2]);
                else n_pass++;
            end
            if (!hs_prev && hso[2]) begin
                n_chk++;
                if (xo[2] !== 16'd1) $display("FAIL pipe3_hs_rise got x=%0d want 1", xo[2]);
                else n_pass++;
            end
            fe_prev = fe[2]; de_prev = deo[2]; hs_prev = hso[2];
        end
    endtask

    task automatic test_ce_div();
        cfg_t c;
        exp_t fq [$];
        exp_t ex;
        logic [2:0] dq [$];
        logic [2:0] want;
        int h, v, n, x_run, eol_run, eol_rise_k;
        logic [15:0] x_prev;
        logic eol_prev, first_change, ce;
        c = cfg[4];
        apply_reset();
        fq.delete(); dq.delete();
        repeat (c.pipe) dq.push_back(3'b000);
        n = 0; x_run = 0; eol_run = 0; eol_rise_k = -1; first_change = 1'b1;
        x_prev = xo[4]; eol_prev = eo[4];
        rst_i = 1'b0;
        for (int k = 0; k < 2 * 2 * ht(c) * vt(c) + 4; k++) begin
            ce = (k % 2 == 0);
            pce[4] = ce;
            if (ce) n++;
            pos(c, n, h, v);
            ex.x = h; ex.y = v;
            ex.fe = (h < c.ha) && (v < c.va);
            ex.sof = (h == 0) && (v == 0);
            ex.eol = (h == ht(c) - 1);
            ex.addr = exp_addr(c, h, v);
            fq.push_back(ex);
            tick();
            ex = fq.pop_front();
            n_chk++;
            if ({xo[4], yo[4], fe[4], so[4], eo[4]} !== {16'(ex.x), 16'(ex.y), ex.fe, ex.sof, ex.eol})
                $display("FAIL cediv_fetch k=%0d got x=%0d y=%0d", k, xo[4], yo[4]);
            else n_pass++;
            if (ex.fe) begin
                n_chk++;
                if (ao[4] !== 19'(ex.addr)) $display("FAIL cediv_addr k=%0d got %0d want %0d", k, ao[4], ex.addr);
                else n_pass++;
            end
            dq.push_back(raw_of(c, h, v));
            want = pins_of(c, dq.pop_front());
            n_chk++;
            if ({hso[4], vso[4], deo[4]} !== want)
                $display("FAIL cediv_pins k=%0d got=%b want=%b", k, {hso[4], vso[4], deo[4]}, want);
            else n_pass++;

            if (xo[4] !== x_prev) begin
                if (!first_change) begin
                    n_chk++;
                    if (x_run !== 2) $display("FAIL cediv_x_hold got %0d want 2", x_run);
                    else n_pass++;
                end
                first_change = 1'b0;
                x_run = 0;
            end
            x_run++;

            if (!eol_prev && eo[4]) begin
                if (eol_rise_k >= 0) begin
                    n_chk++;
                    if (k - eol_rise_k !== 28) $display("FAIL cediv_line got %0d want 28", k - eol_rise_k);
                    else n_pass++;
                end
                eol_rise_k = k;
                eol_run = 0;
            end
            if (eo[4]) eol_run++;
            if (eol_prev && !eo[4] && eol_rise_k >= 0) begin
                n_chk++;
                if (eol_run !== 2) $display("FAIL cediv_eol_len got %0d want 2", eol_run);
                else n_pass++;
            end
            x_prev = xo[4]; eol_prev = eo[4];
        end
    endtask

    task automatic test_mid_reset();
        cfg_t c;
        int h, v, n;
        logic hit, ce;
        c = cfg[4];
        apply_reset();
        n = 0; hit = 1'b0;
        rst_i = 1'b0;
        for (int k = 0; k < 400 && !hit; k++) begin
            ce = (k % 2 == 0);
            pce[4] = ce;
            if (ce) n++;
            tick();
            pos(c, n, h, v);
            if (h == 5 && v == 2) hit = 1'b1;
        end
        n_chk++;
        if (!hit || {xo[4], yo[4], deo[4]} !== {16'd5, 16'd2, 1'b1})
            $display("FAIL midrst_pre got x=%0d y=%0d de=%b want 5/2/1", xo[4], yo[4], deo[4]);
        else n_pass++;

        rst_i = 1'b1;
        pce[4] = 1'b1;
        tick();
        n_chk++;
        if ({fe[4], deo[4], hso[4], vso[4], xo[4], yo[4], so[4], eo[4]} !== {4'b0000, 16'd13, 16'd6, 1'b0, 1'b1})
            $display("FAIL midrst_state got fe=%b de=%b hs=%b vs=%b x=%0d y=%0d",
                     fe[4], deo[4], hso[4], vso[4], xo[4], yo[4]);
        else n_pass++;

        rst_i = 1'b0;
        pce[4] = 1'b0;
        tick();
        n_chk++;
        if ({fe[4], deo[4], hso[4], vso[4], xo[4]} !== {4'b0000, 16'd13})
            $display("FAIL midrst_hold got fe=%b de=%b hs=%b vs=%b x=%0d", fe[4], deo[4], hso[4], vso[4], xo[4]);
        else n_pass++;

        pce[4] = 1'b1;
        tick();
        n_chk++;
        if ({xo[4], yo[4], so[4], fe[4], ao[4]} !== {16'd0, 16'd0, 1'b1, 1'b1, 19'd100})
            $display("FAIL midrst_first got x=%0d y=%0d sof=%b fe=%b addr=%0d", xo[4], yo[4], so[4], fe[4], ao[4]);
        else n_pass++;
        pce = '0;
    endtask

    initial begin
        cfg[0] = '{640, 16, 96, 48, 4, 1, 2, 2, 0, 0, 1, 1, 640, 0, 2};
        cfg[1] = '{640, 16, 96, 48, 6, 1, 1, 1, 0, 0, 2, 2, 320, 16, 2};
        cfg[2] = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 1, 1, 8, 0, 3};
        cfg[3] = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 1, 1, 8, 0, 0};
        cfg[4] = '{8, 2, 2, 2, 4, 1, 1, 1, 1, 1, 1, 1, 8, 100, 2};
        rst_i = 1'b1;
        pce   = '0;
        test_reset();
        test_sync_de();
        test_fetch();
        test_scaled();
        test_pipe();
        test_ce_div();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the video path. It is the successor to the fixed 640x480 controller, with:
- all horizontal and vertical timing values and sync polarities set by parameters;
- a pixel clock enable, so it runs from the system clock;
- a scaled framebuffer address generator with pixel/line repetition;
- a configurable delay that aligns sync and data-enable outputs with framebuffer read latency.

It sits between the framebuffer reader and the DAC/pin drivers.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, front porch (pixels)
- H_SYNC, 96, sync width (pixels)
- H_BACK, 48, back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FRONT, 10, front porch (lines)
- V_SYNC, 2, sync width (lines)
- V_BACK, 33, back porch (lines)
- HS_POL, 0, asserted level of hs
- VS_POL, 0, asserted level of vs
- SCALE_X, 1, output pixels per framebuffer pixel (≥1)
- SCALE_Y, 1, output lines per framebuffer line (≥1)
- STRIDE, 640, address increment per framebuffer line
- BASE, 0, framebuffer address of pixel (0,0)
- ADDR_W, 19, address width
- PIPE, 2, clock-cycle delay from fetch side to hs/vs/de (0 = none)

Ports:
- clock  in  1  system clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- pix_ce  in  1  pixel strobe; counters advance only on clocks with pix_ce=1
- x  out  16  horizontal counter h (0..H_TOTAL-1)
- y  out  16  vertical counter v (0..V_TOTAL-1)
- fetch_en  out  1  h<H_ACTIVE && v<V_ACTIVE (undelayed)
- addr  out  ADDR_W  framebuffer address of the current pixel (undelayed)
- sof  out  1  h==0 && v==0
- eol  out  1  h==H_TOTAL-1
- hs  out  1  horizontal sync, delayed PIPE clocks
- vs  out  1  vertical sync, delayed PIPE clocks
- de  out  1  fetch_en delayed PIPE clocks

## Operation
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK. V_TOTAL is defined the same way. Both must be ≤65535.
- Horizontal region order: active, front porch, sync, back porch. Vertical order is the same.
- Counters update on clocks with pix_ce=1:
  - h wraps from H_TOTAL-1 to 0;
  - v increments when h wraps;
  - v wraps from V_TOTAL-1 to 0.
- Raw hs (active): H_ACTIVE+H_FRONT ≤ h < H_ACTIVE+H_FRONT+H_SYNC.
- Raw vs (active): V_ACTIVE+V_FRONT ≤ v < V_ACTIVE+V_FRONT+V_SYNC. vs changes only where h becomes 0.
- Output level: a pin is at its *_POL level when its raw signal is active, otherwise at the inverse.
- Address generator state:
  - line base lb;
  - sub-pixel counter xs (0..SCALE_X-1);
  - sub-line counter ys (0..SCALE_Y-1).
  - No dividers or multipliers.
- Address generator updates, on each pix_ce:
  - Moving to (0,0): lb=BASE, addr=BASE, xs=0, ys=0.
  - Advancing within an active line: if xs==SCALE_X-1, then xs=0 and addr+=1; else xs+=1.
  - Moving to h=0 of a new line after an active line (v<V_ACTIVE): xs=0.
    - If ys==SCALE_Y-1: ys=0, lb+=STRIDE, addr=lb+STRIDE.
    - Else: ys+=1, addr=lb.
  - All address arithmetic is modulo 2^ADDR_W.
- addr is only meaningful while fetch_en=1. In blanking it holds its value.
- Delay line: raw hs, raw vs and fetch_en are shifted through PIPE registers every clock, independent of pix_ce.

## Timing
- Reset: h=H_TOTAL-1, v=V_TOTAL-1, lb=BASE, addr=BASE, xs=0, ys=0, all delay stages cleared to inactive.
- Output values while rst_i is high and on the clock after release:
  - x=H_TOTAL-1, y=V_TOTAL-1;
  - fetch_en=0, sof=0, eol=1;
  - de=0;
  - hs=~HS_POL, vs=~VS_POL.
- The first pix_ce after reset moves the counters to (0,0): sof=1, fetch_en=1, addr=BASE.
- Fetch-side outputs (x, y, fetch_en, addr, sof, eol) are functions of registered state and change on the clock edge where pix_ce=1.
- hs/vs/de equal their raw versions from exactly PIPE clocks earlier.
- Reset mid-frame takes effect on the next edge and discards the frame and delay-line contents. No partial sync pulse is emitted after reset; the output goes straight to inactive.
- pix_ce held low freezes all fetch-side outputs. The delay line keeps shifting, so hs/vs/de settle to the raw values after PIPE clocks.
- The last active pixel (H_ACTIVE-1, V_ACTIVE-1) at scale 1 gives addr = BASE + (V_ACTIVE-1)*STRIDE + H_ACTIVE-1. The counters then continue into blanking and wrap to (0,0) after V_TOTAL lines.

## Test plan
1. Defaults, pix_ce=1:
   - hs low for exactly 96 of every 800 clocks, first low at x=656;
   - vs low for 1600 clocks every 420000;
   - de high 640 clocks per line for 480 lines.
2. Defaults, addr check:
   - at (0,0), addr=0;
   - at (639,0), addr=639;
   - at (0,1), addr=640;
   - at (639,479), addr=307199;
   - the next sof reloads addr to 0.
3. SCALE_X=2, SCALE_Y=2, STRIDE=320, BASE=16:
   - line 0 addr sequence 16,16,17,17,…,335,335;
   - line 1 repeats line 0;
   - line 2 starts at 336;
   - last active addr is 16+239*320+319=76815.
4. PIPE=3:
   - de rises exactly 3 clocks after fetch_en;
   - hs edges lag the raw x thresholds by 3 clocks;
   - PIPE=0: de equals fetch_en in the same cycle.
5. Small timing (H 8/2/2/2, V 4/1/1/1) with pix_ce high every 2nd clock:
   - a line lasts 28 clocks;
   - x holds for 2 clocks per value;
   - eol lasts 2 clocks.
6. Small timing, rst_i for one clock at x=5, y=2:
   - next cycle: fetch_en=0, de=0, hs/vs inactive;
   - first pix_ce after release gives x=0, y=0, sof=1, addr=BASE.
